// File: rtl/hazard_stall_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared decode constants and small decode helpers for the ID/EX hazard and
// stall controller: MIPS opcode/funct values, EX destination-select codes and
// per-opcode source-usage functions.
// -----------------------------------------------------------------------------
package hazard_stall_unit_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes touching HI/LO
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // EX destination-register select
    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_NONE = 2'b11
    } regdst_e;

    // True for the four multi-cycle HI/LO producers.
    function automatic logic is_muldiv_funct(input logic [5:0] funct);
        logic r;
        case (funct)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // True for any R-type that reads or writes HI/LO.
    function automatic logic is_hilo_user(input logic [5:0] op, input logic [5:0] funct);
        logic r;
        r = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: r = 1'b1;
                default:                            r = is_muldiv_funct(funct);
            endcase
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // rs is read by everything except the absolute jumps and LUI.
    function automatic logic uses_rs(input logic [5:0] op);
        logic r;
        case (op)
            OP_J, OP_JAL, OP_LUI: r = 1'b0;
            default:              r = 1'b1;
        endcase
        return r;
    endfunction

    // rt is a source only for R-type, compare branches and stores.
    function automatic logic uses_rt(input logic [5:0] op);
        logic r;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_muldiv_busy_tracker.sv
// -----------------------------------------------------------------------------
// muldiv_busy_tracker
// Counts down the remaining EX cycles of a MULT/DIV so that HI/LO consumers in
// ID can be held until the result is valid.
// Ports:
//   clk_i   pipeline clock
//   rst_i   asynchronous active-high reset
//   mdx_i   a MULT/MULTU/DIV/DIVU is in EX this cycle
//   busy_o  HI/LO not yet valid (muldiv in EX or countdown running)
// -----------------------------------------------------------------------------
module muldiv_busy_tracker
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 4,
    parameter int unsigned CNT_W          = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mdx_i,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] ZERO_VAL = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;

    // Next count: a new muldiv only arms an idle counter; a running count
    // keeps draining regardless of stalls or flushes and stops at zero.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (mdx_i && (md_cnt_q == ZERO_VAL)) begin
            md_cnt_d = LOAD_VAL;
        end else if (md_cnt_q != ZERO_VAL) begin
            md_cnt_d = md_cnt_q - ONE_VAL;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Countdown register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            md_cnt_q <= ZERO_VAL;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy_o = mdx_i | (md_cnt_q != ZERO_VAL);

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Consumer-side controller for the ID/EX pipeline register. Each cycle it lets
// ID advance, inserts a bubble (load-use or HI/LO hazard), or flushes IF/ID and
// ID/EX on a taken branch resolved in EX.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   IFIDInstruction     instruction in ID
//   IDEXInstruction     instruction in EX
//   IDEXMemRead/RegWrite/RegDst   EX control bits
//   BranchTaken         taken branch/JR resolved in EX (pulse)
//   PCWrite, IFIDWrite  front-end write enables (0 = hold)
//   ControlMuxsignal    1 = pass ID controls, 0 = bubble
//   IFIDFlush, IDEXFlush  synchronous clears for the next edge
//   StallCycles, FlushCycles  saturating performance counters
// Build option: define HAZARD_PERF_EN to implement the performance counters;
// otherwise both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 4,
    parameter int unsigned CNT_W          = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IFIDInstruction,
    input  logic [31:0] IDEXInstruction,
    input  logic        IDEXMemRead,
    input  logic        IDEXRegWrite,
    input  logic [1:0]  IDEXRegDst,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        ControlMuxsignal,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
);

    logic [5:0] id_op_s;
    logic [4:0] id_rs_s;
    logic [4:0] id_rt_s;
    logic [5:0] id_funct_s;
    logic [5:0] ex_op_s;
    logic [5:0] ex_funct_s;
    logic [4:0] ex_dest_s;
    logic       ex_dest_vld_s;
    logic       lu_s;
    logic       mdx_s;
    logic       hl_s;
    logic       hh_s;
    logic       busy_s;
    logic       stall_s;
    logic       unused_bits_s;

    assign id_op_s    = IFIDInstruction[31:26];
    assign id_rs_s    = IFIDInstruction[25:21];
    assign id_rt_s    = IFIDInstruction[20:16];
    assign id_funct_s = IFIDInstruction[5:0];
    assign ex_op_s    = IDEXInstruction[31:26];
    assign ex_funct_s = IDEXInstruction[5:0];

    // Fields not involved in hazard detection.
    assign unused_bits_s = ^{IFIDInstruction[15:6], IDEXInstruction[25:21], IDEXInstruction[10:6]};

    // EX destination register; REGDST_NONE means the instruction writes nothing.
    always_comb begin
        ex_dest_s     = 5'd0;
        ex_dest_vld_s = 1'b0;
        case (regdst_e'(IDEXRegDst))
            REGDST_RT: begin
                ex_dest_s     = IDEXInstruction[20:16];
                ex_dest_vld_s = 1'b1;
            end
            REGDST_RD: begin
                ex_dest_s     = IDEXInstruction[15:11];
                ex_dest_vld_s = 1'b1;
            end
            REGDST_RA: begin
                ex_dest_s     = 5'd31;
                ex_dest_vld_s = 1'b1;
            end
            default: begin
                ex_dest_s     = 5'd0;
                ex_dest_vld_s = 1'b0;
            end
        endcase
    end

    // $0 is hard-wired, so a load targeting it can never create a hazard.
    assign lu_s = IDEXMemRead & IDEXRegWrite & ex_dest_vld_s & (ex_dest_s != 5'd0) &
                  ((uses_rs(id_op_s) & (ex_dest_s == id_rs_s)) |
                   (uses_rt(id_op_s) & (ex_dest_s == id_rt_s)));

    assign mdx_s   = (ex_op_s == OP_RTYPE) & is_muldiv_funct(ex_funct_s);
    assign hl_s    = is_hilo_user(id_op_s, id_funct_s);
    assign hh_s    = hl_s & busy_s;
    assign stall_s = lu_s | hh_s;

    muldiv_busy_tracker #(
        .MULDIV_LATENCY (MULDIV_LATENCY),
        .CNT_W          (CNT_W)
    ) u_busy (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .mdx_i  (mdx_s),
        .busy_o (busy_s)
    );

    // Pipeline control: reset forces free-running, then branch flush beats stall.
    always_comb begin
        PCWrite          = 1'b1;
        IFIDWrite        = 1'b1;
        ControlMuxsignal = 1'b1;
        IFIDFlush        = 1'b0;
        IDEXFlush        = 1'b0;
        if (Reset) begin
            PCWrite          = 1'b1;
            IFIDWrite        = 1'b1;
            ControlMuxsignal = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush        = 1'b1;
            IDEXFlush        = 1'b1;
        end else if (stall_s) begin
            PCWrite          = 1'b0;
            IFIDWrite        = 1'b0;
            ControlMuxsignal = 1'b0;
        end else begin
            PCWrite          = 1'b1;
            IFIDWrite        = 1'b1;
            ControlMuxsignal = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_cycles_q;
    logic [31:0] flush_cycles_d;

    // Saturating counters; a branch cycle counts as a flush, never as a stall.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (BranchTaken) begin
            if (flush_cycles_q != CNT_MAX) begin
                flush_cycles_d = flush_cycles_q + 32'd1;
            end else begin
                flush_cycles_d = flush_cycles_q;
            end
        end else if (stall_s) begin
            if (stall_cycles_q != CNT_MAX) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
        end else begin
            stall_cycles_d = stall_cycles_q;
            flush_cycles_d = flush_cycles_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cycles_q <= 32'd0;
            flush_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCycles = flush_cycles_q;
`else
    assign StallCycles = 32'd0;
    assign FlushCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed scenarios with literal expectations followed by random stimulus,
// all checked every cycle against a behavioural model of the stall rules.
// The HI/LO model tracks the cycle at which HI/LO becomes valid rather than a
// countdown register.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int LAT = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] IFIDInstruction = 32'd0;
    logic [31:0] IDEXInstruction = 32'd0;
    logic        IDEXMemRead = 1'b0;
    logic        IDEXRegWrite = 1'b0;
    logic [1:0]  IDEXRegDst = 2'd0;
    logic        BranchTaken = 1'b0;
    logic        PCWrite, IFIDWrite, ControlMuxsignal, IFIDFlush, IDEXFlush;
    logic [31:0] StallCycles, FlushCycles;

    always #5 Clk = ~Clk;

    hazard_stall_unit #(.MULDIV_LATENCY(LAT), .CNT_W(3)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IFIDInstruction  (IFIDInstruction),
        .IDEXInstruction  (IDEXInstruction),
        .IDEXMemRead      (IDEXMemRead),
        .IDEXRegWrite     (IDEXRegWrite),
        .IDEXRegDst       (IDEXRegDst),
        .BranchTaken      (BranchTaken),
        .PCWrite          (PCWrite),
        .IFIDWrite        (IFIDWrite),
        .ControlMuxsignal (ControlMuxsignal),
        .IFIDFlush        (IFIDFlush),
        .IDEXFlush        (IDEXFlush),
        .StallCycles      (StallCycles),
        .FlushCycles      (FlushCycles)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint hilo_valid_at = 0;   // first cycle index at which HI/LO is free
    longint m_stalls = 0;
    longint m_flushes = 0;

    // Last sampled outputs, for literal checks in the directed section.
    logic        s_pcw, s_ifw, s_cmux, s_iff, s_exf;
    logic [31:0] s_sc, s_fc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int remaining();
        return (hilo_valid_at > cyc) ? int'(hilo_valid_at - cyc) : 0;
    endfunction

    function automatic bit is_muldiv(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        return (op == 0) && (fn >= 'h18) && (fn <= 'h1B);
    endfunction

    function automatic bit is_hilo(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        return (op == 0) && (((fn >= 'h10) && (fn <= 'h13)) || ((fn >= 'h18) && (fn <= 'h1B)));
    endfunction

    function automatic bit load_use();
        int op = int'(IFIDInstruction[31:26]);
        int rs = int'(IFIDInstruction[25:21]);
        int rt = int'(IFIDInstruction[20:16]);
        bit rs_used = !(op == 'h02 || op == 'h03 || op == 'h0F);
        bit rt_used = (op == 0 || op == 'h04 || op == 'h05 || op == 'h28 || op == 'h29 || op == 'h2B);
        int d;
        case (IDEXRegDst)
            2'd0:    d = int'(IDEXInstruction[20:16]);
            2'd1:    d = int'(IDEXInstruction[15:11]);
            2'd2:    d = 31;
            default: d = -1;
        endcase
        return IDEXMemRead && IDEXRegWrite && (d > 0) &&
               ((rs_used && d == rs) || (rt_used && d == rt));
    endfunction

    function automatic bit stall_now();
        bit hh = is_hilo(IFIDInstruction) && (is_muldiv(IDEXInstruction) || remaining() > 0);
        return load_use() || hh;
    endfunction

    function automatic logic [31:0] sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // Compare all outputs against the model (called once per cycle).
    task automatic check_all();
        logic e_pcw, e_cmux, e_fl;
        logic [31:0] e_sc, e_fc;
        if (Reset) begin
            hilo_valid_at = 0;
            m_stalls = 0;
            m_flushes = 0;
        end
        e_fl   = !Reset && BranchTaken;
        e_pcw  = Reset || BranchTaken || !stall_now();
        e_cmux = e_pcw;
`ifdef HAZARD_PERF_EN
        e_sc = sat(m_stalls);
        e_fc = sat(m_flushes);
`else
        e_sc = 32'd0;
        e_fc = 32'd0;
`endif
        chk("PCWrite", {31'd0, PCWrite}, {31'd0, e_pcw});
        chk("IFIDWrite", {31'd0, IFIDWrite}, {31'd0, e_pcw});
        chk("ControlMuxsignal", {31'd0, ControlMuxsignal}, {31'd0, e_cmux});
        chk("IFIDFlush", {31'd0, IFIDFlush}, {31'd0, e_fl});
        chk("IDEXFlush", {31'd0, IDEXFlush}, {31'd0, e_fl});
        chk("StallCycles", StallCycles, e_sc);
        chk("FlushCycles", FlushCycles, e_fc);
        s_pcw = PCWrite; s_ifw = IFIDWrite; s_cmux = ControlMuxsignal;
        s_iff = IFIDFlush; s_exf = IDEXFlush; s_sc = StallCycles; s_fc = FlushCycles;
    endtask

    // Advance model state across a clock edge using the inputs of that cycle.
    task automatic update();
        if (Reset) begin
            hilo_valid_at = 0;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            if (BranchTaken) m_flushes++;
            else if (stall_now()) m_stalls++;
            if (is_muldiv(IDEXInstruction) && remaining() == 0)
                hilo_valid_at = cyc + LAT;
        end
        cyc++;
    endtask

    task automatic cycle();
        @(negedge Clk);
        check_all();
        @(posedge Clk);
        update();
        #1;
    endtask

    task automatic set_in(input logic [31:0] ifid, input logic [31:0] idex,
                          input logic mr, input logic rw, input logic [1:0] rd, input logic bt);
        IFIDInstruction = ifid;
        IDEXInstruction = idex;
        IDEXMemRead     = mr;
        IDEXRegWrite    = rw;
        IDEXRegDst      = rd;
        BranchTaken     = bt;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0004};
    endfunction

    function automatic logic [31:0] rand_instr();
        int ops[10] = '{'h23, 'h04, 'h05, 'h28, 'h29, 'h2B, 'h02, 'h03, 'h0F, 'h08};
        int fns[10] = '{'h20, 'h10, 'h11, 'h12, 'h13, 'h18, 'h19, 'h1A, 'h1B, 'h08};
        int rs = $urandom_range(0, 3);
        int rt = $urandom_range(0, 3);
        int rd = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0)
            return rtype(rs, rt, rd, fns[$urandom_range(0, 9)]);
        else
            return itype(ops[$urandom_range(0, 9)], rs, rt);
    endfunction

    logic [31:0] lw8, lw0, add9, add0, jmp, mult, mfhi;
    int n_stall;

    initial begin
        lw8  = itype('h23, 29, 8);
        lw0  = itype('h23, 29, 0);
        add9 = rtype(8, 10, 9, 'h20);
        add0 = rtype(0, 0, 9, 'h20);
        jmp  = {6'h02, 26'h0000100};
        mult = rtype(4, 5, 0, 'h18);
        mfhi = rtype(0, 0, 6, 'h10);

        #1;
        // Reset values
        cycle();
        chk("rst_pcw", {31'd0, s_pcw}, 32'd1);
        chk("rst_iff", {31'd0, s_iff}, 32'd0);
        Reset = 1'b0;
        cycle();

        // Load-use: one stall, then release once the bubble clears MemRead
        set_in(add9, lw8, 1'b1, 1'b1, 2'd0, 1'b0);
        cycle();
        chk("lu_pcw", {31'd0, s_pcw}, 32'd0);
        chk("lu_cmux", {31'd0, s_cmux}, 32'd0);
        set_in(add9, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle();
        chk("lu_release", {31'd0, s_pcw}, 32'd1);

        // $0 destination and non-reading jump never stall
        set_in(add0, lw0, 1'b1, 1'b1, 2'd0, 1'b0);
        cycle();
        chk("lw0_nostall", {31'd0, s_pcw}, 32'd1);
        set_in(jmp, lw8, 1'b1, 1'b1, 2'd0, 1'b0);
        cycle();
        chk("j_nostall", {31'd0, s_pcw}, 32'd1);

        // Branch beats load-use
        set_in(add9, lw8, 1'b1, 1'b1, 2'd0, 1'b1);
        cycle();
        chk("br_iff", {31'd0, s_iff}, 32'd1);
        chk("br_exf", {31'd0, s_exf}, 32'd1);
        chk("br_pcw", {31'd0, s_pcw}, 32'd1);
        chk("br_cmux", {31'd0, s_cmux}, 32'd1);
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle();

        // MULT then MFHI: LAT stall cycles, issue on the next one
        n_stall = 0;
        set_in(mfhi, mult, 1'b0, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_pcw) break;
            n_stall++;
            set_in(mfhi, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        end
        chk("md_stall_len", n_stall, 32'd4);
`ifdef HAZARD_PERF_EN
        chk("perf_stalls", s_sc, 32'd5);
        chk("perf_flushes", s_fc, 32'd1);
`endif
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle();

        // Reset in the middle of a HI/LO stall
        set_in(mfhi, mult, 1'b0, 1'b0, 2'd3, 1'b0);
        cycle();
        set_in(mfhi, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle();
        chk("md_mid_stall", {31'd0, s_pcw}, 32'd0);
        Reset = 1'b1;
        cycle();
        chk("rst_mid_pcw", {31'd0, s_pcw}, 32'd1);
        chk("rst_mid_cmux", {31'd0, s_cmux}, 32'd1);
        chk("rst_mid_sc", s_sc, 32'd0);
        Reset = 1'b0;
        cycle();
        chk("post_rst_nostall", {31'd0, s_pcw}, 32'd1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 99) == 0);
            set_in(rand_instr(), rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Consumer-side controller for the ID/EX pipeline register. It decides every cycle whether ID may hand its instruction to ID/EX, or whether ID/EX must receive a bubble or a flush.
- Drives PC/IF-ID write enables, the control-mux bubble select, and the IF/ID and ID/EX flush lines (the ID/EX flush is the register's synchronous-clear input).
- Tracks a multi-cycle MULT/DIV occupying HI/LO and stalls dependent HI/LO instructions until the result is ready.

Parameters:
- MULDIV_LATENCY, 4, total EX cycles (>=2) before HI/LO are valid after MULT/MULTU/DIV/DIVU enters EX.
- CNT_W, 3, width of the muldiv busy counter; must hold MULDIV_LATENCY-1.

Ports:
- Clk  in  1  pipeline clock.
- Reset  in  1  asynchronous active-high reset.
- IFIDInstruction  in  32  instruction currently in ID.
- IDEXInstruction  in  32  instruction currently in EX (from ID/EX).
- IDEXMemRead  in  1  EX instruction is a load.
- IDEXRegWrite  in  1  EX instruction writes the register file.
- IDEXRegDst  in  2  EX destination select: 00 rt[20:16], 01 rd[15:11], 10 $31, 11 none.
- BranchTaken  in  1  EX-resolved taken branch/jump-register, one-cycle pulse.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID load enable.
- ControlMuxsignal  out  1  1 = pass ID controls, 0 = insert bubble (all-zero controls).
- IFIDFlush  out  1  clear IF/ID next edge.
- IDEXFlush  out  1  clear ID/EX next edge.
- StallCycles  out  32  performance counter (see optional feature).
- FlushCycles  out  32  performance counter (see optional feature).

Behaviour:
- Outputs are combinational from the registered state plus the current inputs.
- Only state: busy counter md_cnt[CNT_W-1:0] and the optional performance counters.
- Reset (async): md_cnt=0 and performance counters=0. While Reset=1: PCWrite=1, IFIDWrite=1, ControlMuxsignal=1, IFIDFlush=0, IDEXFlush=0.
- ID decode:
  - rs = IFIDInstruction[25:21], rt = [20:16].
  - rt is a source for R-type (op 0x00), BEQ/BNE (0x04/0x05), and stores SB/SH/SW (0x28/0x29/0x2B).
  - rs is a source for every opcode except J/JAL (0x02/0x03) and LUI (0x0F).
- EX dest: selected by IDEXRegDst from IDEXInstruction; code 11 means no destination.
- Load-use hazard (lu): IDEXMemRead & IDEXRegWrite & dest!=0 & dest matches a used ID source.
- muldiv-in-EX (mdx): IDEXInstruction op 0x00 with funct 0x18/0x19/0x1A/0x1B.
- ID HI/LO user (hl): op 0x00 with funct 0x10/0x11/0x12/0x13, or any muldiv funct.
- HI/LO hazard (hh): hl & (mdx | md_cnt!=0).
- Busy counter, per clock edge:
  - if mdx & md_cnt==0, load MULDIV_LATENCY-1;
  - else if md_cnt!=0, decrement;
  - otherwise hold.
  - It counts through flushes and stalls and never wraps below 0.
- Priority, highest first:
  1. BranchTaken: IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1, ControlMuxsignal=1. Any stall is discarded.
  2. hh or lu (stall): PCWrite=0, IFIDWrite=0, ControlMuxsignal=0, both flushes 0.
  3. Otherwise: PCWrite=1, IFIDWrite=1, ControlMuxsignal=1, both flushes 0.
- Latency:
  - A load-use stall lasts exactly 1 cycle; the bubble clears IDEXMemRead.
  - A HI/LO user issued immediately after a MULT stalls MULDIV_LATENCY cycles in total.
- Boundaries:
  - A destination of $0 never stalls.
  - lu and hh together count as a single stall cycle.
  - Reset asserted mid-stall aborts it immediately.

Optional Feature:
- HAZARD_PERF_EN defined:
  - StallCycles increments on each clock with Reset=0, BranchTaken=0 and a stall condition (lu or hh).
  - FlushCycles increments on each clock with Reset=0 and BranchTaken=1.
  - Both counters saturate at 32'hFFFFFFFF and clear on Reset.
- Not defined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared package/header holds:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LUI, OP_SB, OP_SH, OP_SW;
  - funct constants: FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU;
  - RegDst codes REGDST_RT, REGDST_RD, REGDST_RA, REGDST_NONE.
- One sub-module, muldiv_busy_tracker: owns md_cnt and outputs busy = mdx | md_cnt!=0.

Test Plan:
- Load-use: IDEX=LW $8 (MemRead=1, RegWrite=1, RegDst=00), IFID=ADD $9,$8,$10 -> one cycle of PCWrite=0, IFIDWrite=0, ControlMuxsignal=0, then all 1.
- IDEX=LW $0, IFID=ADD $9,$0,$0 -> no stall. IDEX=LW $8, IFID=J 0x100 -> no stall.
- Branch priority: load-use present and BranchTaken=1 in the same cycle -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, ControlMuxsignal=1.
- MULT then MFHI with MULDIV_LATENCY=4 -> exactly 4 stall cycles; md_cnt goes 3,2,1,0; MFHI issues on the 5th cycle.
- Reset pulse while md_cnt=2 -> md_cnt=0 at once, outputs at Reset values, no stall after release.
- With HAZARD_PERF_EN: scenarios 1 and 4 back-to-back plus one branch -> StallCycles=5, FlushCycles=1.
